decode_stage_p: RTL

Parametrised instruction-decode pipeline stage. It turns a 32-bit instruction word into one-hot register selects (A, B, D) and ALU/memory control (Imm, S, Cin, LW, SW), then registers them for the execute stage.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/onehot_dec.sv | 15 +
 rtl/decode_stage_p.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared opcode/funct encodings, ALU function codes and the decoded control bundle
// for the decode stage.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000011;
   localparam logic [5:0] OP_SUBI  = 6'b000010;
   localparam logic [5:0] OP_XORI  = 6'b000001;
   localparam logic [5:0] OP_ANDI  = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b011110;
   localparam logic [5:0] OP_SW    = 6'b011111;

   localparam logic [5:0] FN_ADD = 6'b000011;
   localparam logic [5:0] FN_SUB = 6'b000010;
   localparam logic [5:0] FN_XOR = 6'b000001;
   localparam logic [5:0] FN_AND = 6'b000111;
   localparam logic [5:0] FN_OR  = 6'b000100;

   typedef enum logic [2:0] {
      S_XOR = 3'b000,
      S_ADD = 3'b010,
      S_SUB = 3'b011,
      S_OR  = 3'b100,
      S_AND = 3'b110,
      S_NOP = 3'b111
   } alu_fn_e;

   typedef struct packed {
      logic       imm;
      logic [2:0] s;
      logic       cin;
      logic       lw;
      logic       sw;
   } ctrl_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot select decoder.
module onehot_dec #(
   parameter int unsigned N = 32,
   localparam int unsigned AW = $clog2(N)
) (
   input  logic [AW-1:0] i_idx,
   output logic [N-1:0]  o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/decode_stage_p.sv
// Instruction decode pipeline stage: decodes ibus into one-hot register selects and ALU/memory
// controls, with valid/ready handshake, stall/flush and load-use bubble insertion.
module decode_stage_p
   import decode_pkg::*;
#(
   parameter int unsigned NREG         = 32,
   parameter bit          ZERO_WB_KILL = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     ibus,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            stall_in,
   input  logic            flush,
   output logic            out_valid,
   output logic [NREG-1:0] Aselect,
   output logic [NREG-1:0] Bselect,
   output logic [NREG-1:0] Dselect,
   output logic            Imm,
   output logic [2:0]      S,
   output logic            Cin,
   output logic            LW,
   output logic            SW,
   output logic [31:0]     Imm32,
   output logic            hazard
);

   localparam int unsigned AW = $clog2(NREG);

   logic [5:0]      w_op;
   logic [5:0]      w_fn;
   logic [AW-1:0]   w_rs;
   logic [AW-1:0]   w_rt;
   logic [AW-1:0]   w_rd;
   logic [AW-1:0]   w_dest_idx;
   logic            w_dest_kill;
   logic            w_use_rt;
   logic            w_hazard;
   ctrl_t           w_ctrl;
   logic [31:0]     w_imm32;
   logic [NREG-1:0] w_asel;
   logic [NREG-1:0] w_bsel;
   logic [NREG-1:0] w_dsel;

   logic            r_out_valid;
   logic [NREG-1:0] r_asel;
   logic [NREG-1:0] r_bsel;
   logic [NREG-1:0] r_dsel;
   ctrl_t           r_ctrl;
   logic [31:0]     r_imm32;
   logic [AW-1:0]   r_dest_idx;

   assign w_op    = ibus[31:26];
   assign w_fn    = ibus[5:0];
   assign w_rs    = ibus[21 +: AW];
   assign w_rt    = ibus[16 +: AW];
   assign w_rd    = ibus[11 +: AW];
   assign w_imm32 = {{16{ibus[15]}}, ibus[15:0]};

   // Unknown encodings fall through to the NOP bundle (S=111, Imm=1).
   always_comb begin
      w_ctrl   = '{imm: 1'b1, s: S_NOP, cin: 1'b0, lw: 1'b0, sw: 1'b0};
      w_use_rt = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_use_rt = 1'b1;
            case (w_fn)
               FN_ADD:  w_ctrl = '{imm: 1'b0, s: S_ADD, cin: 1'b0, lw: 1'b0, sw: 1'b0};
               FN_SUB:  w_ctrl = '{imm: 1'b0, s: S_SUB, cin: 1'b1, lw: 1'b0, sw: 1'b0};
               FN_XOR:  w_ctrl = '{imm: 1'b0, s: S_XOR, cin: 1'b0, lw: 1'b0, sw: 1'b0};
               FN_AND:  w_ctrl = '{imm: 1'b0, s: S_AND, cin: 1'b0, lw: 1'b0, sw: 1'b0};
               FN_OR:   w_ctrl = '{imm: 1'b0, s: S_OR,  cin: 1'b0, lw: 1'b0, sw: 1'b0};
               default: ;
            endcase
         end
         OP_ADDI: w_ctrl.s = S_ADD;
         OP_SUBI: begin
            w_ctrl.s   = S_SUB;
            w_ctrl.cin = 1'b1;
         end
         OP_XORI: w_ctrl.s = S_XOR;
         OP_ANDI: w_ctrl.s = S_AND;
         OP_ORI:  w_ctrl.s = S_OR;
         OP_LW: begin
            w_ctrl.s  = S_ADD;
            w_ctrl.lw = 1'b1;
         end
         OP_SW: begin
            w_ctrl.s  = S_ADD;
            w_ctrl.sw = 1'b1;
            w_use_rt  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_dest_idx  = w_ctrl.imm ? w_rt : w_rd;
   assign w_dest_kill = w_ctrl.sw || (ZERO_WB_KILL && (w_dest_idx == '0));

   onehot_dec #(.N(NREG)) u_dec_a (.i_idx(w_rs),       .o_onehot(w_asel));
   onehot_dec #(.N(NREG)) u_dec_b (.i_idx(w_rt),       .o_onehot(w_bsel));
   onehot_dec #(.N(NREG)) u_dec_d (.i_idx(w_dest_idx), .o_onehot(w_dsel));

   // Load-use: the registered load's destination feeds a source the incoming instruction reads.
   assign w_hazard = in_valid && r_out_valid && r_ctrl.lw && (r_dest_idx != '0) &&
                     ((r_dest_idx == w_rs) || (w_use_rt && (r_dest_idx == w_rt)));

   assign in_ready = !stall_in && !w_hazard;
   assign hazard   = w_hazard;

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         r_out_valid <= 1'b0;
         r_asel      <= '0;
         r_bsel      <= '0;
         r_dsel      <= '0;
         r_ctrl      <= '0;
         r_imm32     <= '0;
         r_dest_idx  <= '0;
      end else if (!stall_in) begin
         if (w_hazard) begin
            r_out_valid <= 1'b0;
            r_asel      <= '0;
            r_bsel      <= '0;
            r_dsel      <= '0;
            r_ctrl      <= '0;
            r_imm32     <= '0;
            r_dest_idx  <= '0;
         end else begin
            r_out_valid <= in_valid;
            r_asel      <= w_asel;
            r_bsel      <= w_bsel;
            r_imm32     <= w_imm32;
            if (in_valid) begin
               r_ctrl     <= w_ctrl;
               r_dsel     <= w_dest_kill ? '0 : w_dsel;
               r_dest_idx <= w_dest_idx;
            end else begin
               r_ctrl     <= '0;
               r_dsel     <= '0;
               r_dest_idx <= '0;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign Aselect   = r_asel;
   assign Bselect   = r_bsel;
   assign Dselect   = r_dsel;
   assign Imm       = r_ctrl.imm;
   assign S         = r_ctrl.s;
   assign Cin       = r_ctrl.cin;
   assign LW        = r_ctrl.lw;
   assign SW        = r_ctrl.sw;
   assign Imm32     = r_imm32;

endmodule
